// File: rtl/add_share_arb.sv
// add_share_arb
// Round-robin scheduler that shares one single-cycle-latency W-bit adder
// among N requesters. One operand pair is accepted at a time. The block
// pulses the adder's start input, captures the result and returns it to
// the requester that won the grant. It also flags an adder valid that never
// arrives (timeout) and an adder valid that arrives unexpectedly (spurious).
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   req_valid[N]  per-requester request
//   req_a/req_b   packed operands, requester i at bits [i*W +: W]
//   req_ready[N]  one-hot accept pulse (combinational, only in IDLE)
//   add_start     start pulse to the shared adder
//   add_a/add_b   operands to the adder, held until the next accept
//   add_y         adder result
//   add_valid     adder result valid
//   rsp_valid[N]  one-hot response pulse
//   rsp_data      result, valid with rsp_valid and held afterwards
//   busy          high whenever the scheduler is not idle
//   err_timeout   sticky: adder valid did not arrive in time
//   err_spurious  sticky: adder valid arrived outside the wait window
module add_share_arb #(
    parameter int W       = 20,
    parameter int N       = 4,
    parameter int TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [N-1:0]   req_ready,
    output logic           add_start,
    output logic [W-1:0]   add_a,
    output logic [W-1:0]   add_b,
    input  logic [W-1:0]   add_y,
    input  logic           add_valid,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_data,
    output logic           busy,
    output logic           err_timeout,
    output logic           err_spurious
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state_r;
    logic [PW-1:0] ptr_r;
    logic [PW-1:0] gnt_r;
    logic [CW-1:0] cnt_r;
    logic          add_start_r;
    logic [W-1:0]  add_a_r;
    logic [W-1:0]  add_b_r;
    logic [N-1:0]  rsp_valid_r;
    logic [W-1:0]  rsp_data_r;
    logic          busy_r;
    logic          err_timeout_r;
    logic          err_spurious_r;

    logic          found_s;
    logic [PW-1:0] grant_s;
    logic [PW:0]   idx_s;
    logic [W-1:0]  sel_a_s;
    logic [W-1:0]  sel_b_s;

    // One-hot decode of a requester index.
    function automatic logic [N-1:0] onehot(input logic [PW-1:0] i);
        onehot = {{(N-1){1'b0}}, 1'b1} << i;
    endfunction

    // Round-robin successor of a requester index, wrapping at N.
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        if (i == PW'(N - 1)) begin
            next_idx = '0;
        end else begin
            next_idx = i + PW'(1);
        end
    endfunction

    // Grant search: first requester with req_valid, scanning from ptr upward
    // with wrap. The index is kept one bit wider so ptr+k never overflows
    // before the modulo-N fold.
    always_comb begin
        found_s = 1'b0;
        grant_s = '0;
        idx_s   = '0;
        for (int k = 0; k < N; k++) begin
            idx_s = {1'b0, ptr_r} + (PW+1)'(k);
            if (idx_s >= (PW+1)'(N)) begin
                idx_s = idx_s - (PW+1)'(N);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_valid[idx_s[PW-1:0]]) begin
                found_s = 1'b1;
                grant_s = idx_s[PW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Operand mux for the candidate winner.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_s == PW'(i)) begin
                sel_a_s = req_a[i*W +: W];
                sel_b_s = req_b[i*W +: W];
            end else begin
                sel_a_s = sel_a_s;
                sel_b_s = sel_b_s;
            end
        end
    end

    // Accept pulse: the only combinational output, suppressed while in reset.
    always_comb begin
        if ((state_r == IDLE) && found_s && !rst) begin
            req_ready = onehot(grant_s);
        end else begin
            req_ready = '0;
        end
    end

    // Scheduler FSM with all registered outputs and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            ptr_r          <= '0;
            gnt_r          <= '0;
            cnt_r          <= '0;
            add_start_r    <= 1'b0;
            add_a_r        <= '0;
            add_b_r        <= '0;
            rsp_valid_r    <= '0;
            rsp_data_r     <= '0;
            busy_r         <= 1'b0;
            err_timeout_r  <= 1'b0;
            err_spurious_r <= 1'b0;
        end else begin
            // Pulses default low; they are raised for exactly one cycle below.
            add_start_r <= 1'b0;
            rsp_valid_r <= '0;
            if (add_valid && (state_r != WAIT)) begin
                err_spurious_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        gnt_r       <= grant_s;
                        add_a_r     <= sel_a_s;
                        add_b_r     <= sel_b_s;
                        add_start_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_r   <= '0;
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (add_valid) begin
                        rsp_data_r  <= add_y;
                        rsp_valid_r <= onehot(gnt_r);
                        state_r     <= RESP;
                    end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                        // Counter would reach TIMEOUT: abandon the operation.
                        err_timeout_r <= 1'b1;
                        ptr_r         <= next_idx(gnt_r);
                        busy_r        <= 1'b0;
                        state_r       <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                RESP: begin
                    ptr_r   <= next_idx(gnt_r);
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign add_start    = add_start_r;
    assign add_a        = add_a_r;
    assign add_b        = add_b_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_data     = rsp_data_r;
    assign busy         = busy_r;
    assign err_timeout  = err_timeout_r;
    assign err_spurious = err_spurious_r;

endmodule

// File: tb/tb_add_share_arb.sv
// Testbench for add_share_arb: directed scenarios plus randomized operations,
// checked against a transaction-level model (round-robin pointer, expected
// sum and fixed accept/start/response schedule).
module tb_add_share_arb;

    localparam int W       = 20;
    localparam int N       = 4;
    localparam int TIMEOUT = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           add_start;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_y;
    logic           add_valid;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           busy;
    logic           err_timeout;
    logic           err_spurious;

    logic           adder_valid_q;
    logic           suppress = 1'b0;
    logic           inject   = 1'b0;

    int n_checks  = 0;
    int n_pass    = 0;
    int model_ptr = 0;

    add_share_arb #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_y(add_y), .add_valid(add_valid),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .err_timeout(err_timeout), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    // Behavioural single-cycle adder with valid suppression and stray injection.
    always @(posedge clk) begin
        adder_valid_q <= add_start & ~suppress;
        add_y         <= add_a + add_b;
    end
    assign add_valid = adder_valid_q | inject;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int winner(input logic [N-1:0] pat);
        for (int k = 0; k < N; k++) begin
            if (pat[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N*W-1:0] rnd_vec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    // One complete transaction starting in an idle cycle. Returns in the
    // first cycle after the operation where a new accept is possible.
    task automatic do_op(input logic [N-1:0] pat, input logic [N*W-1:0] av,
                         input logic [N*W-1:0] bv, input bit to_mode);
        int           g;
        logic [N-1:0] oh;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [W-1:0] exp_sum;
        bit           saw_rsp;
        req_valid = pat;
        req_a     = av;
        req_b     = bv;
        @(negedge clk);
        if (pat == '0) begin
            check_eq("idle_ready", req_ready, '0);
            step();
            return;
        end
        g       = winner(pat);
        oh      = N'(1) << g;
        ea      = av[g*W +: W];
        eb      = bv[g*W +: W];
        exp_sum = ea + eb;
        check_eq("accept_ready", req_ready, oh);
        step();
        @(negedge clk);
        check_eq("add_start", add_start, 1'b1);
        check_eq("add_a", add_a, ea);
        check_eq("add_b", add_b, eb);
        check_eq("busy_issue", busy, 1'b1);
        check_eq("ready_while_busy", req_ready, '0);
        step();
        @(negedge clk);
        check_eq("start_once", add_start, 1'b0);
        if (!to_mode) begin
            step();
            check_eq("rsp_valid", rsp_valid, oh);
            check_eq("rsp_data", rsp_data, exp_sum);
            step();
            check_eq("rsp_pulse_end", rsp_valid, '0);
            check_eq("busy_done", busy, 1'b0);
            check_eq("rsp_data_held", rsp_data, exp_sum);
        end else begin
            saw_rsp = 1'b0;
            repeat (TIMEOUT - 1) begin
                step();
                if (rsp_valid != '0) saw_rsp = 1'b1;
            end
            check_eq("timeout_early", err_timeout, 1'b0);
            check_eq("busy_waiting", busy, 1'b1);
            step();
            if (rsp_valid != '0) saw_rsp = 1'b1;
            check_eq("timeout_set", err_timeout, 1'b1);
            check_eq("busy_timeout", busy, 1'b0);
            check_eq("no_rsp_timeout", saw_rsp, 1'b0);
        end
        model_ptr = (g + 1) % N;
    endtask

    initial begin
        logic [N*W-1:0] av;
        logic [N*W-1:0] bv;
        bit             saw_rsp;

        // Reset held three cycles with every requester asking.
        rst       = 1'b1;
        req_valid = '1;
        req_a     = rnd_vec();
        req_b     = rnd_vec();
        repeat (3) begin
            step();
            @(negedge clk);
            check_eq("rst_ready", req_ready, '0);
            check_eq("rst_start", add_start, 1'b0);
        end
        check_eq("rst_rsp_valid", rsp_valid, '0);
        check_eq("rst_rsp_data", rsp_data, '0);
        check_eq("rst_add_a", add_a, '0);
        check_eq("rst_add_b", add_b, '0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_err_timeout", err_timeout, 1'b0);
        check_eq("rst_err_spurious", err_spurious, 1'b0);
        step();
        rst = 1'b0;

        // Round robin with everyone requesting, then only 1 and 3.
        repeat (5) do_op(4'b1111, rnd_vec(), rnd_vec(), 1'b0);
        do_op(4'b1010, rnd_vec(), rnd_vec(), 1'b0);
        do_op(4'b1010, rnd_vec(), rnd_vec(), 1'b0);

        // Single request from requester 2.
        av = rnd_vec();
        bv = rnd_vec();
        av[2*W +: W] = 20'h003E8;
        bv[2*W +: W] = 20'h00007;
        do_op(4'b0100, av, bv, 1'b0);

        // Result wraps modulo 2^W.
        av[0 +: W] = 20'hFFFFF;
        bv[0 +: W] = 20'h00002;
        do_op(4'b0001, av, bv, 1'b0);

        // Adder never answers, then a normal operation follows.
        suppress = 1'b1;
        do_op(4'b1000, rnd_vec(), rnd_vec(), 1'b1);
        suppress = 1'b0;
        do_op(4'b1111, rnd_vec(), rnd_vec(), 1'b0);

        // Reset in the WAIT cycle, coinciding with the adder valid.
        req_valid = 4'b0100;
        req_a     = rnd_vec();
        req_b     = rnd_vec();
        step();
        step();
        rst       = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_rsp", rsp_valid, '0);
        check_eq("midrst_err_spurious", err_spurious, 1'b0);
        check_eq("midrst_err_timeout", err_timeout, 1'b0);
        saw_rsp = 1'b0;
        repeat (4) begin
            step();
            if (rsp_valid != '0) saw_rsp = 1'b1;
        end
        check_eq("midrst_no_rsp", saw_rsp, 1'b0);
        model_ptr = 0;
        do_op(4'b1111, rnd_vec(), rnd_vec(), 1'b0);

        // Stray adder valid while idle.
        req_valid = '0;
        check_eq("spurious_before", err_spurious, 1'b0);
        inject = 1'b1;
        step();
        inject = 1'b0;
        check_eq("spurious_set", err_spurious, 1'b1);

        // Randomized operations, including idle cycles.
        for (int t = 0; t < 40; t++) begin
            do_op(N'($urandom), rnd_vec(), rnd_vec(), 1'b0);
        end
        check_eq("spurious_sticky", err_spurious, 1'b1);
        check_eq("timeout_clear", err_timeout, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/add_share_arb.md
# add_share_arb

Round-robin scheduler that shares one single-cycle-latency W-bit adder (start/a/b in, y/valid out one cycle later) among N requesters. Accepts one operand pair at a time, sequences the adder's start pulse, captures its result and returns it to the winning requester. Sits between the requester clients and the adder instance in the same clock domain. Also detects a missing or spurious adder valid.

## Interface
- W, 20: operand/result width
- N, 4: number of requesters (2..16)
- TIMEOUT, 8: max cycles to wait for add_valid after add_start (>=2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  N  per-requester request
- req_a  in  N*W  operand a, requester i at bits [i*W +: W]
- req_b  in  N*W  operand b, same packing
- req_ready  out  N  one-hot accept pulse
- add_start  out  1  start pulse to adder
- add_a, add_b  out  W each  operands to adder
- add_y  in  W  adder result
- add_valid  in  1  adder result valid
- rsp_valid  out  N  one-hot response pulse
- rsp_data  out  W  result, valid with rsp_valid
- busy  out  1  high whenever state != IDLE
- err_timeout  out  1  sticky: add_valid missing
- err_spurious  out  1  sticky: add_valid outside WAIT

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, pick grant g = first set bit scanning ptr, ptr+1, ..., wrapping mod N. Drive req_ready[g]=1 combinationally in that cycle. Latch req_a/req_b slice g and g into registers. Next state ISSUE. No request: stay IDLE.
- ISSUE: add_start=1, add_a/add_b = latched operands. Clear wait counter. Next state WAIT.
- WAIT: if add_valid, register add_y into rsp_data and go to RESP. Otherwise increment the counter. When the counter reaches TIMEOUT, set err_timeout, advance ptr to (g+1) mod N, go to IDLE, and issue no response.
- RESP: rsp_valid[g]=1 for exactly one cycle, rsp_data held. Set ptr=(g+1) mod N. Next state IDLE.
- add_valid seen in IDLE, ISSUE or RESP sets err_spurious and is otherwise ignored.
- Error flags are cleared only by rst.
- req_valid may drop at any time without an accept; no state is kept for unaccepted requests.
- Arithmetic: no width change. rsp_data is exactly add_y (modulo 2^W, as produced by the adder).

## Timing
- Reset values: state IDLE, ptr 0, req_ready 0, add_start 0, add_a/add_b 0, rsp_valid 0, rsp_data 0, busy 0, both error flags 0.
- rst high in any state forces reset values at the next edge. An in-flight operation is dropped with no response. A late add_valid after reset does not set err_spurious during the rst cycle.
- Cycle schedule with a nominal adder:
  - accept in cycle T (IDLE)
  - add_start in T+1
  - add_valid in T+2
  - rsp_valid in T+3
  - next accept possible in T+4
- Throughput: one operation per 4 cycles.
- add_a/add_b hold the latched operands from ISSUE until the next accept.
- add_start is never high for two consecutive cycles.
- Simultaneous requests: exactly one req_ready bit per accept. The winner is decided by ptr only; it does not depend on the order in which requests arrived.
- Timeout: with no add_valid, err_timeout rises TIMEOUT+1 cycles after the add_start cycle. busy falls in the same cycle.
- All outputs except req_ready are registered.

## Test plan
- Reset: hold rst 3 cycles with req_valid=4'b1111 -> all outputs 0, no req_ready, no add_start. Release -> req_ready=4'b0001 next cycle.
- Single request: req 2 with a=0x003E8, b=0x00007 -> req_ready=4'b0100 at T, add_start at T+1 with a/b as given, rsp_valid=4'b0100 and rsp_data=0x003EF at T+3.
- Round-robin: all four requesting continuously -> grant order 0,1,2,3,0, each 4 cycles apart. Then only 1 and 3 request after a grant to 1 -> next grant is 3.
- Wrap-around: a=0xFFFFF, b=0x00002 -> rsp_data=0x00001.
- Timeout: adder model suppresses valid -> err_timeout set 9 cycles after add_start, no rsp_valid, next grant proceeds normally. Inject a stray add_valid in IDLE -> err_spurious=1.
- Reset mid-operation: assert rst in the WAIT cycle -> no rsp_valid ever for that operation, ptr=0, busy=0 the following cycle.
